bus_slot_arbiter: RTL and testbench
===================================

# bus_slot_arbiter

Memory-slot scheduler for the GSTMCU DRAM bus. Runs in the clk32 domain, consumes the slot strobe and slot type derived from the clock generator's cycsel phase, and grants each 250 ns memory slot to exactly one owner. Video slots go to shifter fetch or DRAM refresh. Bus slots go to DMA, blitter or CPU, with blitter burst/yield sharing.

## Interface
Parameters:
- REF_INTERVAL, 32: slots between refresh requests; legal range 2..255.
- BLIT_BURST, 64: blitter slots per burst, and the length of the following CPU yield window, in bus slots; legal range 1..255.

Ports:
- clk32  in  1  system clock, 32 MHz; the only clock.
- resb  in  1  synchronous reset, active-low, sampled on posedge clk32.
- slot_en  in  1  one-clk32 pulse at the start of each memory slot, every 8 clk32.
- cycsel  in  1  slot type, sampled with slot_en: 1 = video slot, 0 = bus slot.
- vid_req  in  1  shifter fetch pending (level).
- dma_req, blit_req, cpu_req  in  1 each  bus requests (levels).
- blit_hog  in  1  1 = blitter never yields.
- grant  out  5  one-hot owner of the current slot: bit0 vid, bit1 ref, bit2 dma, bit3 blit, bit4 cpu; 0 = idle.
- ack  out  5  one-clk32 pulse, same encoding, marking retirement of the previous slot's owner.
- ref_pend  out  2  pending refresh count (debug).

## Operation
- All decisions are taken only on clk32 edges where slot_en=1; between strobes every output except ack holds.
- Video slot (cycsel=1):
  - ref_pend==3: refresh.
  - Else vid_req: video.
  - Else ref_pend>0: refresh.
  - Else idle.
- Bus slot (cycsel=0), fixed priority:
  - dma_req.
  - Else blit_req and the blitter is eligible.
  - Else cpu_req.
  - Else idle.
- Refresh timer:
  - Slot counter runs 0..REF_INTERVAL-1 on every slot_en and wraps.
  - On wrap, ref_pend increments, saturating at 3; a tick arriving at 3 is lost.
  - Each refresh grant decrements ref_pend.
  - Tick and refresh grant on the same strobe leave ref_pend unchanged.
- Blitter sharing FSM (states B_IDLE, B_BURST, B_YIELD), evaluated on bus-slot strobes only:
  - B_IDLE: the blitter is eligible. A blitter grant moves to B_BURST with burst count 1.
  - B_BURST: eligible. Each blitter grant increments the count.
    - Count reaching BLIT_BURST with blit_hog=0 moves to B_YIELD with the yield counter cleared.
    - blit_req=0 on a bus strobe returns to B_IDLE.
  - B_YIELD: not eligible. The yield counter increments on every bus strobe, whether the slot is granted to CPU, DMA or left idle. At BLIT_BURST it returns to B_IDLE.
  - A DMA grant during B_BURST does not advance the burst count.
  - blit_hog=1 keeps the FSM out of B_YIELD. Asserting blit_hog while in B_YIELD returns to B_IDLE on the next bus strobe.
- ack carries the old grant value on each strobe where the old grant is nonzero, independent of the new owner (same owner twice still pulses ack).

## Timing
- grant and ack are registered. The new grant is visible on the clk32 edge that samples slot_en, i.e. it appears 1 clk32 after slot_en goes high.
- ack is high for exactly that one clk32.
- Request latency: a request that is asserted and winning at a strobe is granted in that slot. Requests arriving mid-slot wait for the next strobe of the matching type.
- Reset (resb=0 at an edge), including mid-slot:
  - grant=0, ack=0, ref_pend=0.
  - Slot, burst and yield counters = 0; FSM = B_IDLE.
  - No ack is issued for an owner cut off by reset.
- slot_en during reset is ignored. The first strobe after release arbitrates normally.
- If slot_en stops, the grant holds indefinitely.

## Structure
- Package bus_arb_pkg holds:
  - Grant bit indices GNT_VID=0, GNT_REF=1, GNT_DMA=2, GNT_BLIT=3, GNT_CPU=4.
  - The blitter FSM state enum.
  - Grant width 5.
- Sub-module refresh_timer (slot counter plus saturating ref_pend, with inputs tick and ref_grant) is natural.
- Arbitration and the blitter FSM stay in the top.

## Test plan
- Reset, then 40 video strobes with vid_req=0 (REF_INTERVAL=32) -> refresh granted in the slot after the first wrap; ref_pend returns to 0; all other video slots idle.
- vid_req=1 held for 100 slots -> ref_pend saturates at 3; the next video slot grants ref (bit1) despite vid_req, then video resumes.
- blit_req=cpu_req=1, blit_hog=0, BLIT_BURST=4 -> bus slots go blit×4, cpu×4, blit×4; ack trails each grant by exactly one slot strobe.
- Same as above with dma_req pulsed for 2 bus slots mid-burst -> DMA takes both slots; the burst still totals 4 blitter grants.
- blit_hog=1 with all bus requests asserted except DMA -> blitter owns every bus slot and the CPU is never granted.
- resb=0 for one clk32 while grant=blit in B_BURST -> grant=0, no ack, ref_pend=0; the next bus strobe re-enters B_BURST with count 1.

Source files
------------

// File: rtl/bus_slot_arbiter_pkg.sv
// rtl/bus_slot_arbiter_pkg.sv - shared grant encoding and blitter FSM states for the slot arbiter
package bus_arb_pkg;

    localparam int GNT_W    = 5;
    localparam int GNT_VID  = 0;
    localparam int GNT_REF  = 1;
    localparam int GNT_DMA  = 2;
    localparam int GNT_BLIT = 3;
    localparam int GNT_CPU  = 4;

    typedef logic [GNT_W-1:0] grant_t;

    typedef enum logic [1:0] {
        B_IDLE  = 2'd0,
        B_BURST = 2'd1,
        B_YIELD = 2'd2
    } blit_state_t;

    // Build a one-hot grant word for a given owner index
    function automatic grant_t grant_onehot(input int idx);
        grant_t g;
        g = '0;
        g[idx] = 1'b1;
        return g;
    endfunction

endpackage

// File: rtl/bus_slot_arbiter_if.sv
// rtl/bus_slot_arbiter_if.sv - slot strobe, request and grant bundle between requesters and the arbiter
interface bus_slot_arbiter_if;
    import bus_arb_pkg::*;

    logic       slot_en;
    logic       cycsel;
    logic       vid_req;
    logic       dma_req;
    logic       blit_req;
    logic       cpu_req;
    logic       blit_hog;
    grant_t     grant;
    grant_t     ack;
    logic [1:0] ref_pend;

    modport master (
        output slot_en, cycsel, vid_req, dma_req, blit_req, cpu_req, blit_hog,
        input  grant, ack, ref_pend
    );

    modport slave (
        input  slot_en, cycsel, vid_req, dma_req, blit_req, cpu_req, blit_hog,
        output grant, ack, ref_pend
    );

endinterface

// File: rtl/bus_slot_arbiter_refresh_timer.sv
// rtl/bus_slot_arbiter_refresh_timer.sv - slot counter producing saturating refresh debt
module refresh_timer #(
    parameter int REF_INTERVAL = 32
) (
    input  logic       clk32,
    input  logic       resb,
    input  logic       tick,
    input  logic       ref_grant,
    output logic [1:0] ref_pend
);

    localparam logic [7:0] LAST_SLOT = 8'(REF_INTERVAL - 1);

    logic [7:0] slot_cnt;
    logic       wrap;
    logic       take;

    assign wrap = tick && (slot_cnt == LAST_SLOT);
    // A refresh is only ever granted with debt outstanding; guard anyway so debt never underflows
    assign take = tick && ref_grant && (ref_pend != 2'd0);

    // Count slots and keep the refresh debt; a wrap and a refresh in the same slot cancel out
    always_ff @(posedge clk32) begin
        if (!resb) begin
            slot_cnt <= 8'd0;
            ref_pend <= 2'd0;
        end else begin
            if (tick) begin
                slot_cnt <= wrap ? 8'd0 : slot_cnt + 8'd1;
            end
            if (wrap && !take) begin
                if (ref_pend != 2'd3) begin
                    ref_pend <= ref_pend + 2'd1;
                end
            end else if (take && !wrap) begin
                ref_pend <= ref_pend - 2'd1;
            end
        end
    end

endmodule

// File: rtl/bus_slot_arbiter.sv
// rtl/bus_slot_arbiter.sv - grants each 250 ns DRAM slot to video/refresh or DMA/blitter/CPU
module bus_slot_arbiter
    import bus_arb_pkg::*;
#(
    parameter int REF_INTERVAL = 32,
    parameter int BLIT_BURST   = 64
) (
    input  logic                clk32,
    input  logic                resb,
    bus_slot_arbiter_if.slave   bus
);

    localparam logic [7:0] BURST_LEN  = 8'(BLIT_BURST);
    localparam logic [7:0] BURST_LAST = 8'(BLIT_BURST - 1);

    grant_t      grant_q;
    grant_t      ack_q;
    grant_t      next_grant;
    blit_state_t bstate;
    logic [7:0]  burst_cnt;
    logic [7:0]  yield_cnt;
    logic [1:0]  ref_pend;
    logic        blit_elig;
    logic        bus_strobe;
    logic        ref_take;

    assign blit_elig  = (bstate != B_YIELD);
    assign bus_strobe = bus.slot_en && !bus.cycsel;
    assign ref_take   = bus.slot_en && next_grant[GNT_REF];

    refresh_timer #(
        .REF_INTERVAL (REF_INTERVAL)
    ) u_refresh_timer (
        .clk32     (clk32),
        .resb      (resb),
        .tick      (bus.slot_en),
        .ref_grant (ref_take),
        .ref_pend  (ref_pend)
    );

    // Pick the owner of the slot that starts at this strobe
    always_comb begin
        next_grant = '0;
        if (bus.cycsel) begin
            if (ref_pend == 2'd3) begin
                next_grant = grant_onehot(GNT_REF);
            end else if (bus.vid_req) begin
                next_grant = grant_onehot(GNT_VID);
            end else if (ref_pend != 2'd0) begin
                next_grant = grant_onehot(GNT_REF);
            end
        end else begin
            if (bus.dma_req) begin
                next_grant = grant_onehot(GNT_DMA);
            end else if (bus.blit_req && blit_elig) begin
                next_grant = grant_onehot(GNT_BLIT);
            end else if (bus.cpu_req) begin
                next_grant = grant_onehot(GNT_CPU);
            end
        end
    end

    // Latch the new owner on each strobe and retire the old one with a single-cycle ack
    always_ff @(posedge clk32) begin
        if (!resb) begin
            grant_q <= '0;
            ack_q   <= '0;
        end else if (bus.slot_en) begin
            grant_q <= next_grant;
            ack_q   <= grant_q;
        end else begin
            ack_q   <= '0;
        end
    end

    // Blitter burst/yield sharing, advanced on bus-slot strobes only
    always_ff @(posedge clk32) begin
        if (!resb) begin
            bstate    <= B_IDLE;
            burst_cnt <= 8'd0;
            yield_cnt <= 8'd0;
        end else if (bus_strobe) begin
            case (bstate)
                B_IDLE: begin
                    if (next_grant[GNT_BLIT]) begin
                        // A one-slot burst is already complete on its first grant
                        if ((BURST_LEN == 8'd1) && !bus.blit_hog) begin
                            bstate    <= B_YIELD;
                            burst_cnt <= 8'd0;
                            yield_cnt <= 8'd0;
                        end else begin
                            bstate    <= B_BURST;
                            burst_cnt <= 8'd1;
                        end
                    end
                end
                B_BURST: begin
                    if (!bus.blit_req) begin
                        bstate    <= B_IDLE;
                        burst_cnt <= 8'd0;
                    end else if (next_grant[GNT_BLIT]) begin
                        // Count saturates under hog so dropping hog later yields on the next grant
                        if ((burst_cnt >= BURST_LAST) && !bus.blit_hog) begin
                            bstate    <= B_YIELD;
                            burst_cnt <= 8'd0;
                            yield_cnt <= 8'd0;
                        end else if (burst_cnt < BURST_LEN) begin
                            burst_cnt <= burst_cnt + 8'd1;
                        end
                    end
                end
                B_YIELD: begin
                    if (bus.blit_hog || (yield_cnt == BURST_LAST)) begin
                        bstate    <= B_IDLE;
                        yield_cnt <= 8'd0;
                    end else begin
                        yield_cnt <= yield_cnt + 8'd1;
                    end
                end
                default: begin
                    bstate    <= B_IDLE;
                    burst_cnt <= 8'd0;
                    yield_cnt <= 8'd0;
                end
            endcase
        end
    end

    assign bus.grant    = grant_q;
    assign bus.ack      = ack_q;
    assign bus.ref_pend = ref_pend;

endmodule

// File: tb/tb_bus_slot_arbiter.sv
// tb/tb_bus_slot_arbiter.sv - directed and randomized checks of the slot arbiter against a slot-level model
module tb_bus_slot_arbiter;

    localparam int RI = 32;
    localparam int BB = 4;

    localparam logic [4:0] G_IDLE = 5'b00000;
    localparam logic [4:0] G_VID  = 5'b00001;
    localparam logic [4:0] G_REF  = 5'b00010;
    localparam logic [4:0] G_DMA  = 5'b00100;
    localparam logic [4:0] G_BLIT = 5'b01000;
    localparam logic [4:0] G_CPU  = 5'b10000;

    logic clk32;
    logic resb;

    bus_slot_arbiter_if bus();

    bus_slot_arbiter #(
        .REF_INTERVAL (RI),
        .BLIT_BURST   (BB)
    ) dut (
        .clk32 (clk32),
        .resb  (resb),
        .bus   (bus)
    );

    initial clk32 = 1'b0;
    always #5 clk32 = ~clk32;

    int checks = 0;
    int errors = 0;

    // Reference model: slot-level bookkeeping
    int         m_slot;
    int         m_pend;
    int         m_burst;
    int         m_yield;
    logic [4:0] m_prev;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_slot  = 0;
        m_pend  = 0;
        m_burst = 0;
        m_yield = 0;
        m_prev  = G_IDLE;
    endtask

    task automatic model_step(input bit cyc, output logic [4:0] g, output logic [4:0] a);
        a = m_prev;
        g = G_IDLE;
        if (cyc) begin
            if (m_pend == 3)      g = G_REF;
            else if (bus.vid_req) g = G_VID;
            else if (m_pend > 0)  g = G_REF;
        end else begin
            if (bus.dma_req)                        g = G_DMA;
            else if (bus.blit_req && m_yield == 0)  g = G_BLIT;
            else if (bus.cpu_req)                   g = G_CPU;
            if (m_yield > 0) begin
                if (bus.blit_hog) m_yield = 0;
                else              m_yield--;
            end else if (g == G_BLIT) begin
                m_burst = (m_burst + 1 > BB) ? BB : m_burst + 1;
                if (m_burst == BB && !bus.blit_hog) begin
                    m_yield = BB;
                    m_burst = 0;
                end
            end else if (!bus.blit_req) begin
                m_burst = 0;
            end
        end
        if (g == G_REF) m_pend--;
        m_slot = (m_slot + 1) % RI;
        if (m_slot == 0 && m_pend < 3) m_pend++;
        m_prev = g;
    endtask

    // One full 8-cycle slot: strobe, then check ack pulse width and grant hold
    task automatic do_slot(input bit cyc, output logic [4:0] g_obs);
        logic [4:0] eg;
        logic [4:0] ea;
        @(negedge clk32);
        bus.slot_en = 1'b1;
        bus.cycsel  = cyc;
        model_step(cyc, eg, ea);
        @(posedge clk32);
        #1;
        bus.slot_en = 1'b0;
        chk("grant", 8'(bus.grant), 8'(eg));
        chk("ack", 8'(bus.ack), 8'(ea));
        chk("ref_pend", 8'(bus.ref_pend), 8'(m_pend));
        g_obs = bus.grant;
        @(posedge clk32);
        #1;
        chk("ack_width", 8'(bus.ack), 8'd0);
        repeat (6) @(posedge clk32);
        #1;
        chk("grant_hold", 8'(bus.grant), 8'(eg));
    endtask

    task automatic pulse_reset(input bit strobe_during);
        @(negedge clk32);
        resb        = 1'b0;
        bus.slot_en = strobe_during;
        bus.cycsel  = 1'b0;
        @(posedge clk32);
        #1;
        resb        = 1'b1;
        bus.slot_en = 1'b0;
        model_reset();
        chk("rst_grant", 8'(bus.grant), 8'd0);
        chk("rst_ack", 8'(bus.ack), 8'd0);
        chk("rst_ref_pend", 8'(bus.ref_pend), 8'd0);
    endtask

    task automatic set_reqs(input bit vid, input bit dma, input bit blit, input bit cpu, input bit hog);
        bus.vid_req  = vid;
        bus.dma_req  = dma;
        bus.blit_req = blit;
        bus.cpu_req  = cpu;
        bus.blit_hog = hog;
    endtask

    initial begin
        logic [4:0] g;
        logic [4:0] pat_a [12];
        logic [4:0] pat_b [10];
        int         nref;
        int         maxp;
        int         ncpu;

        resb        = 1'b0;
        bus.slot_en = 1'b0;
        bus.cycsel  = 1'b0;
        set_reqs(0, 0, 0, 0, 0);
        model_reset();
        repeat (3) @(posedge clk32);
        pulse_reset(1'b1);

        // Idle video slots: one refresh right after the first counter wrap
        nref = 0;
        for (int i = 1; i <= 40; i++) begin
            do_slot(1'b1, g);
            if (g == G_REF) nref++;
            if (i == 33) chk("ref_after_wrap", 8'(g), 8'(G_REF));
        end
        chk("ref_count_idle", 8'(nref), 8'd1);
        chk("ref_pend_drained", 8'(bus.ref_pend), 8'd0);

        // Continuous video: debt saturates at 3 and then wins one slot over video
        set_reqs(1, 0, 0, 0, 0);
        nref = 0;
        maxp = 0;
        for (int k = 1; k <= 100; k++) begin
            do_slot(1'b1, g);
            if (g == G_REF) nref++;
            if (int'(bus.ref_pend) > maxp) maxp = int'(bus.ref_pend);
            if (k == 89) chk("ref_over_vid", 8'(g), 8'(G_REF));
            if (k == 90) chk("vid_resumes", 8'(g), 8'(G_VID));
        end
        chk("ref_sat_seen", 8'(maxp), 8'd3);
        chk("ref_count_vid", 8'(nref), 8'd1);

        // Blitter burst then CPU yield window
        pat_a = '{G_BLIT, G_BLIT, G_BLIT, G_BLIT, G_CPU, G_CPU, G_CPU, G_CPU,
                  G_BLIT, G_BLIT, G_BLIT, G_BLIT};
        set_reqs(0, 0, 1, 1, 0);
        for (int i = 0; i < 12; i++) begin
            do_slot(1'b0, g);
            chk("burst_yield_pat", 8'(g), 8'(pat_a[i]));
        end
        for (int i = 0; i < 4; i++) begin
            do_slot(1'b0, g);
            chk("yield_tail", 8'(g), 8'(G_CPU));
        end

        // DMA steals two slots mid-burst without consuming burst length
        pat_b = '{G_BLIT, G_BLIT, G_DMA, G_DMA, G_BLIT, G_BLIT, G_CPU, G_CPU, G_CPU, G_CPU};
        for (int i = 0; i < 10; i++) begin
            bus.dma_req = (i == 2 || i == 3);
            do_slot(1'b0, g);
            chk("dma_mid_burst", 8'(g), 8'(pat_b[i]));
        end
        bus.dma_req = 1'b0;

        // Hog: blitter keeps every bus slot
        bus.blit_hog = 1'b1;
        ncpu = 0;
        for (int i = 0; i < 20; i++) begin
            do_slot(1'b0, g);
            if (g == G_CPU) ncpu++;
            chk("hog_blit", 8'(g), 8'(G_BLIT));
        end
        chk("hog_no_cpu", 8'(ncpu), 8'd0);
        bus.blit_hog = 1'b0;

        // Reset mid-burst, then a fresh burst of full length
        pulse_reset(1'b0);
        do_slot(1'b0, g);
        chk("pre_reset_blit", 8'(g), 8'(G_BLIT));
        pulse_reset(1'b1);
        for (int i = 0; i < 5; i++) begin
            do_slot(1'b0, g);
            chk("post_reset_pat", 8'(g), 8'((i < 4) ? G_BLIT : G_CPU));
        end

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            bus.vid_req  = 1'($urandom_range(0, 1));
            bus.dma_req  = ($urandom_range(0, 3) == 0);
            bus.blit_req = ($urandom_range(0, 3) != 0);
            bus.cpu_req  = 1'($urandom_range(0, 1));
            bus.blit_hog = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 49) == 0) pulse_reset(1'($urandom_range(0, 1)));
            do_slot(($urandom_range(0, 3) == 0), g);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
